// File: rtl/min_reduce_ctrl.sv
// min_reduce_ctrl
// Streams the N operands of one frame through a single registered 2-input
// minimum stage and returns the frame minimum on a valid/ready output.
//
// Optional feature macro: MIN_REDUCE_CTRL_IDX_EN
//   When defined, adds out_idx, the 0-based position of the first occurrence
//   of the frame minimum. When undefined, the port and index register are absent.
//
// Parameters:
//   DW : operand/result width in bits
//   N  : operands per frame (2..256)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a frame (sampled only in IDLE)
//   clear      synchronous abort to IDLE from any state, highest priority
//   in_valid   operand valid
//   in_ready   controller accepts operand
//   in_data    operand, unsigned
//   out_valid  frame result valid
//   out_ready  consumer accepts result
//   out_min    running/final minimum (held between frames)
//   busy       high in RUN and DONE
//   out_idx    position of first minimum (MIN_REDUCE_CTRL_IDX_EN only)
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start, no operand accepted
// RUN   | accepting operands, folding each into acc
// DONE  | result presented, held until out_ready
module min_reduce_ctrl #(
    parameter int DW = 8,
    parameter int N  = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_min,
    output logic          busy
`ifdef MIN_REDUCE_CTRL_IDX_EN
    ,
    output logic [CW-1:0] out_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [DW-1:0] acc;
    logic          run_rdy;
    logic          beat;

`ifdef MIN_REDUCE_CTRL_IDX_EN
    logic [CW-1:0] idx;
    assign out_idx = idx;
`endif

    // run_rdy is the registered RUN-state ready; clear masks it in the same
    // cycle so a beat presented alongside clear is never consumed.
    assign in_ready = run_rdy & ~clear;
    assign beat     = in_valid & in_ready;
    assign out_min  = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            run_rdy   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef MIN_REDUCE_CTRL_IDX_EN
            idx       <= '0;
`endif
        end else if (clear) begin
            // acc (and idx) intentionally keep their value across an abort
            state     <= IDLE;
            count     <= '0;
            run_rdy   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        count   <= '0;
                        run_rdy <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (count == '0) begin
                            acc <= in_data;
`ifdef MIN_REDUCE_CTRL_IDX_EN
                            idx <= '0;
`endif
                        end else if (in_data < acc) begin
                            // strict compare: ties keep the earliest operand
                            acc <= in_data;
`ifdef MIN_REDUCE_CTRL_IDX_EN
                            idx <= count;
`endif
                        end
                        if (count == LAST) begin
                            // counter holds at LAST so it never wraps
                            state     <= DONE;
                            run_rdy   <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start here is ignored, even in the handshake cycle
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    run_rdy   <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
